motor_ramp: RTL and testbench
=============================

# motor_ramp

Soft-start / soft-stop duty controller between the switch-derived motor duty request and the motor `pwm` instance. It slews the applied 12-bit duty toward the requested value at a fixed rate, and ramps down on a distance stop or when run is dropped. Over-current from the H-bridge `OC` pins forces duty to zero and latches a fault. Its `duty` output drives the `width` input of the motor PWM directly.

## Interface
- `WIDTH`, 12: duty width; matches the motor PWM counter width.
- `MAX`, 4095: full-scale duty; `target_duty` above this is clamped to `MAX`.
- `STEP`, 64: duty change per ramp tick.
- `TICK_DIV`, 100000: clock cycles per ramp tick (1 ms at 100 MHz).
- `OC_TICKS`, 4: consecutive ticks with any `OC` bit high that trip a fault.
- `RETRY_TICKS`, 1000: cooldown ticks before auto-retry (macro only).

- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low reset.
- `target_duty` in WIDTH: requested duty (`sw*255` at top level).
- `run` in 1: operator enable (`sw_ON`).
- `stop_req` in 1: obstacle stop (`dist_flag`).
- `OC` in 2: H-bridge over-current, active-high, already synchronous.
- `duty` out WIDTH: applied duty to the motor PWM.
- `active` out 1: `duty` is nonzero.
- `fault` out 1: over-current fault latched.
- `state` out 3: current FSM state, for debug and 7-seg display.

## Operation
- Tick generator: a counter runs 0..TICK_DIV-1 and emits a one-cycle `tick` at the terminal count. It free-runs in every state.
- Priority when events coincide: fault > stop (`stop_req` high or `run` low) > target change.
- **IDLE**: `duty`=0.
  - `run`=1, `stop_req`=0 and `target_duty`>0 → RAMP.
- **RAMP**: on each `tick`, `duty` moves toward the clamped target by `STEP`, saturating exactly at the target with no overshoot.
  - Moving down is allowed if the target drops.
  - `duty`==target → HOLD.
- **HOLD**: `duty` is constant.
  - Target differs from `duty` → RAMP.
  - Target changes to 0 → RAMP down, then IDLE when `duty` reaches 0.
- **BRAKE**: entered from RAMP or HOLD on a stop condition. On each `tick`, `duty` decreases by `STEP`, saturating at 0.
  - `duty`==0 → IDLE.
  - Stop clears while braking → stay in BRAKE until `duty`==0, then IDLE re-evaluates.
- **FAULT**:
  - Entry: an OC counter increments on every tick where `OC`!=0 and clears on any tick where `OC`==0. When it reaches `OC_TICKS` → FAULT from any state.
  - On entry: `duty`=0 and `fault`=1.
  - Exit: `run`=0 → IDLE, which clears `fault` and the OC counter.
- Arithmetic: use WIDTH+1 bits for the add and subtract, then clamp into 0..MAX. There is no wrap-around at either end.
- Target clamping: `target_duty` is clamped to `MAX` combinationally and sampled on each tick.

## Timing
- Reset values: `duty`=0, `active`=0, `fault`=0, `state`=IDLE, tick counter 0, OC counter 0, retry counter 0.
- All outputs are registered.
- `duty` updates on the cycle after `tick`.
- FAULT entry: `duty`=0 and `fault`=1 one cycle after the tripping tick.
- State transitions out of IDLE on `run` or target take one cycle and do not wait for a tick. The first duty step occurs on the next tick.
- Reset asserted mid-ramp: all outputs return to reset values on the next edge.

## Configuration
- `MOTOR_RAMP_OC_RETRY_EN` defined:
  - In FAULT, a retry counter counts ticks with `OC`==0 and clears whenever `OC`!=0.
  - At `RETRY_TICKS` → IDLE, `fault` clears, and the ramp restarts from 0 if `run` is still high.
  - `run`=0 still exits FAULT immediately.
- Undefined: FAULT is left only via `run`=0 or reset, and no retry counter exists.

## Structure
- Shared package `rover_pkg`:
  - State encoding: IDLE=0, RAMP=1, HOLD=2, BRAKE=3, FAULT=4.
  - Default `TICK_DIV` and `STEP` constants.
- Sub-module `ramp_tick`: parameterised divider producing the one-cycle `tick`, with synchronous active-low reset.

## Test plan
Sim parameters: `TICK_DIV`=4, `STEP`=64, `OC_TICKS`=4, `RETRY_TICKS`=8.
- Reset, then `run`=1 and `target_duty`=3825 → `duty` rises 64 per tick, reaches exactly 3825 after 60 ticks, state HOLD.
- In HOLD, pulse `stop_req` for one cycle → BRAKE, `duty` falls 64 per tick to 0 with no underflow, then IDLE and `active`=0.
- In HOLD at 3825, change target to 1000 → ramps down to exactly 1000 and returns to HOLD.
- Hold `OC`=2'b01 for 3 ticks, then clear → no fault. Hold 4 ticks → `duty`=0 and `fault`=1 next cycle. `run`=0 → IDLE and `fault`=0.
- With `MOTOR_RAMP_OC_RETRY_EN`: fault, `OC` cleared, `run` held 1 → after 8 ticks, IDLE then RAMP from 0.
- Drive `target_duty`=4095 with `stop_req` high → stays IDLE with `duty`=0. Assert `reset`=0 mid-ramp → all outputs zero on the next edge.

Source files
------------

// File: rtl/rover_pkg.sv
// Shared rover definitions: motor ramp FSM state encoding and default ramp timing.
package rover_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RAMP  = 3'd1,
    HOLD  = 3'd2,
    BRAKE = 3'd3,
    FAULT = 3'd4
  } ramp_state_t;

  localparam int unsigned RAMP_TICK_DIV = 100000;
  localparam int unsigned RAMP_STEP     = 64;

endpackage

// File: rtl/ramp_tick.sv
// Free-running divider emitting a one-cycle tick at the terminal count of 0..TICK_DIV-1.
module ramp_tick
  import rover_pkg::*;
#(
  parameter int unsigned TICK_DIV = RAMP_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick_c
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (cnt_q == TERM) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick_c = (cnt_q == TERM);

endmodule

// File: rtl/motor_ramp.sv
// Soft-start / soft-stop duty slew controller with over-current fault latch.
// Optional auto-retry out of FAULT when MOTOR_RAMP_OC_RETRY_EN is defined.
module motor_ramp
  import rover_pkg::*;
#(
  parameter int unsigned WIDTH       = 12,
  parameter int unsigned MAX         = 4095,
  parameter int unsigned STEP        = RAMP_STEP,
  parameter int unsigned TICK_DIV    = RAMP_TICK_DIV,
  parameter int unsigned OC_TICKS    = 4,
  parameter int unsigned RETRY_TICKS = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] target_duty,
  input  logic             run,
  input  logic             stop_req,
  input  logic [1:0]       OC,
  output logic [WIDTH-1:0] duty,
  output logic             active,
  output logic             fault,
  output logic [2:0]       state
);

  localparam int unsigned W1  = WIDTH + 1;
  localparam int unsigned OCW = $clog2(OC_TICKS + 1);

  logic tick_c;

  ramp_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .tick_c (tick_c)
  );

  ramp_state_t      state_q, state_n;
  logic [WIDTH-1:0] duty_q, duty_n;
  logic             fault_q, fault_n;
  logic             active_q, active_n;
  logic [OCW-1:0]   oc_cnt_q, oc_cnt_n;

  logic [WIDTH-1:0] tgt_c;
  logic [W1-1:0]    up_sum_c, dn_diff_c;
  logic [WIDTH-1:0] slew_c, brake_c;
  logic             oc_any_c, trip_c, stop_c;

`ifdef MOTOR_RAMP_OC_RETRY_EN
  localparam int unsigned RW = $clog2(RETRY_TICKS + 1);
  logic [RW-1:0] retry_q, retry_n;
`else
  logic retry_param_unused_c;
  assign retry_param_unused_c = (RETRY_TICKS == 0);
`endif

  assign tgt_c     = (target_duty > WIDTH'(MAX)) ? WIDTH'(MAX) : target_duty;
  assign up_sum_c  = {1'b0, duty_q} + W1'(STEP);
  assign dn_diff_c = {1'b0, duty_q} - W1'(STEP);
  assign oc_any_c  = |OC;
  assign stop_c    = stop_req || !run;
  assign trip_c    = tick_c && oc_any_c && ((oc_cnt_q + OCW'(1)) == OCW'(OC_TICKS));

  // One step toward the target, landing exactly on it; the extra bit catches carry/borrow
  always_comb begin
    slew_c = duty_q;
    if (tgt_c > duty_q) begin
      slew_c = (up_sum_c > {1'b0, tgt_c}) ? tgt_c : up_sum_c[WIDTH-1:0];
    end else if (tgt_c < duty_q) begin
      slew_c = (dn_diff_c[WIDTH] || (dn_diff_c[WIDTH-1:0] < tgt_c)) ? tgt_c : dn_diff_c[WIDTH-1:0];
    end
    brake_c = dn_diff_c[WIDTH] ? '0 : dn_diff_c[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      fault_q  <= 1'b0;
      active_q <= 1'b0;
      oc_cnt_q <= '0;
`ifdef MOTOR_RAMP_OC_RETRY_EN
      retry_q  <= '0;
`endif
    end else begin
      state_q  <= state_n;
      duty_q   <= duty_n;
      fault_q  <= fault_n;
      active_q <= active_n;
      oc_cnt_q <= oc_cnt_n;
`ifdef MOTOR_RAMP_OC_RETRY_EN
      retry_q  <= retry_n;
`endif
    end
  end

  // Next state: fault outranks stop, stop outranks target tracking
  always_comb begin
    state_n  = state_q;
    duty_n   = duty_q;
    fault_n  = fault_q;
    oc_cnt_n = oc_cnt_q;
`ifdef MOTOR_RAMP_OC_RETRY_EN
    retry_n  = '0;
`endif
    if (tick_c) begin
      oc_cnt_n = oc_any_c ? (oc_cnt_q + OCW'(1)) : '0;
    end

    if (trip_c && (state_q != FAULT)) begin
      state_n  = FAULT;
      duty_n   = '0;
      fault_n  = 1'b1;
      oc_cnt_n = '0;
    end else begin
      case (state_q)
        IDLE: begin
          duty_n = '0;
          if (!stop_c && (tgt_c != '0)) begin
            state_n = RAMP;
          end
        end
        RAMP: begin
          if (stop_c) begin
            state_n = BRAKE;
          end else begin
            if (tick_c) begin
              duty_n = slew_c;
            end
            if (duty_n == tgt_c) begin
              state_n = (tgt_c == '0) ? IDLE : HOLD;
            end
          end
        end
        HOLD: begin
          if (stop_c) begin
            state_n = BRAKE;
          end else if (tgt_c != duty_q) begin
            state_n = RAMP;
          end
        end
        BRAKE: begin
          if (tick_c) begin
            duty_n = brake_c;
          end
          if (duty_n == '0) begin
            state_n = IDLE;
          end
        end
        FAULT: begin
          duty_n   = '0;
          oc_cnt_n = '0;
          if (!run) begin
            state_n = IDLE;
            fault_n = 1'b0;
          end
`ifdef MOTOR_RAMP_OC_RETRY_EN
          else if (tick_c) begin
            if (oc_any_c) begin
              retry_n = '0;
            end else if ((retry_q + RW'(1)) == RW'(RETRY_TICKS)) begin
              state_n = IDLE;
              fault_n = 1'b0;
            end else begin
              retry_n = retry_q + RW'(1);
            end
          end else begin
            retry_n = retry_q;
          end
`endif
        end
        default: begin
          state_n = IDLE;
          duty_n  = '0;
        end
      endcase
    end
    active_n = (duty_n != '0);
  end

  assign duty   = duty_q;
  assign active = active_q;
  assign fault  = fault_q;
  assign state  = state_q;

endmodule

// File: tb/tb_motor_ramp.sv
// Directed bench for motor_ramp: vector table for ramp/brake/fault paths, hand sequence for retry.
`timescale 1ns/1ps
module tb_motor_ramp;
  import rover_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] target_duty;
  logic        run;
  logic        stop_req;
  logic [1:0]  OC;
  logic [11:0] duty;
  logic        active;
  logic        fault;
  logic [2:0]  state;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef MOTOR_RAMP_OC_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  always #5 clk = ~clk;

  motor_ramp #(
    .WIDTH(12), .MAX(4095), .STEP(64), .TICK_DIV(4), .OC_TICKS(4), .RETRY_TICKS(8)
  ) dut (
    .clk(clk), .reset(reset), .target_duty(target_duty), .run(run), .stop_req(stop_req),
    .OC(OC), .duty(duty), .active(active), .fault(fault), .state(state)
  );

  typedef struct {
    logic        rst_n;
    logic        run;
    logic        stop;
    logic [1:0]  oc;
    logic [11:0] tgt;
    int          cycles;
    logic [11:0] e_duty;
    logic [2:0]  e_state;
    logic        e_fault;
    logic        e_active;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [11:0] d, input logic [2:0] s,
                         input logic f, input logic a);
    chk({name, ".duty"},   16'(duty),   16'(d));
    chk({name, ".state"},  16'(state),  16'(s));
    chk({name, ".fault"},  16'(fault),  16'(f));
    chk({name, ".active"}, 16'(active), 16'(a));
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; stop_req = 1'b0; OC = 2'b00; target_duty = '0;

    // Cycle comments count edges from the last reset edge; ticks land on multiples of 4
    tbl.push_back('{1'b0, 1'b0, 1'b0, 2'b00, 12'd0,    2,   12'd0,    3'(IDLE),  1'b0, 1'b0, "reset"});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b00, 12'd3825, 1,   12'd0,    3'(RAMP),  1'b0, 1'b0, "start"});      // 1
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b00, 12'd3825, 3,   12'd64,   3'(RAMP),  1'b0, 1'b1, "up1"});        // 4
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b00, 12'd3825, 4,   12'd128,  3'(RAMP),  1'b0, 1'b1, "up2"});        // 8
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b00, 12'd3825, 232, 12'd3825, 3'(HOLD),  1'b0, 1'b1, "up60"});       // 240
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b00, 12'd3825, 4,   12'd3825, 3'(HOLD),  1'b0, 1'b1, "hold"});       // 244
    tbl.push_back('{1'b1, 1'b1, 1'b1, 2'b00, 12'd3825, 1,   12'd3825, 3'(BRAKE), 1'b0, 1'b1, "stop"});       // 245
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b00, 12'd3825, 3,   12'd3761, 3'(BRAKE), 1'b0, 1'b1, "brk1"});       // 248
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b00, 12'd3825, 232, 12'd49,   3'(BRAKE), 1'b0, 1'b1, "brk59"});      // 480
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b00, 12'd3825, 4,   12'd0,    3'(IDLE),  1'b0, 1'b0, "brk_end"});    // 484
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b00, 12'd3825, 1,   12'd0,    3'(RAMP),  1'b0, 1'b0, "restart"});    // 485
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b00, 12'd3825, 239, 12'd3825, 3'(HOLD),  1'b0, 1'b1, "reup"});       // 724
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b00, 12'd1000, 1,   12'd3825, 3'(RAMP),  1'b0, 1'b1, "tgt_dn"});     // 725
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b00, 12'd1000, 3,   12'd3761, 3'(RAMP),  1'b0, 1'b1, "dn1"});        // 728
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b00, 12'd1000, 172, 12'd1009, 3'(RAMP),  1'b0, 1'b1, "dn44"});       // 900
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b00, 12'd1000, 4,   12'd1000, 3'(HOLD),  1'b0, 1'b1, "dn_sat"});     // 904
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b01, 12'd1000, 12,  12'd1000, 3'(HOLD),  1'b0, 1'b1, "oc3"});        // 916
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b00, 12'd1000, 4,   12'd1000, 3'(HOLD),  1'b0, 1'b1, "oc_clr"});     // 920
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b01, 12'd1000, 12,  12'd1000, 3'(HOLD),  1'b0, 1'b1, "oc3b"});       // 932
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b01, 12'd1000, 4,   12'd0,    3'(FAULT), 1'b1, 1'b0, "oc_trip"});    // 936
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b00, 12'd1000, 8,   12'd0,    3'(FAULT), 1'b1, 1'b0, "flt_hold"});   // 944
    tbl.push_back('{1'b1, 1'b0, 1'b0, 2'b00, 12'd1000, 1,   12'd0,    3'(IDLE),  1'b0, 1'b0, "flt_exit"});   // 945
    tbl.push_back('{1'b1, 1'b1, 1'b1, 2'b00, 12'd4095, 8,   12'd0,    3'(IDLE),  1'b0, 1'b0, "idle_stop"});  // 953
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b00, 12'd4095, 1,   12'd0,    3'(RAMP),  1'b0, 1'b0, "go_max"});     // 954
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b00, 12'd4095, 6,   12'd128,  3'(RAMP),  1'b0, 1'b1, "max2"});       // 960
    tbl.push_back('{1'b1, 1'b0, 1'b0, 2'b00, 12'd4095, 1,   12'd128,  3'(BRAKE), 1'b0, 1'b1, "run_drop"});   // 961
    tbl.push_back('{1'b1, 1'b0, 1'b0, 2'b00, 12'd4095, 3,   12'd64,   3'(BRAKE), 1'b0, 1'b1, "rd1"});        // 964
    tbl.push_back('{1'b1, 1'b0, 1'b0, 2'b00, 12'd4095, 4,   12'd0,    3'(IDLE),  1'b0, 1'b0, "rd_end"});     // 968
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b00, 12'd4095, 9,   12'd128,  3'(RAMP),  1'b0, 1'b1, "mid_ramp"});   // 977
    tbl.push_back('{1'b0, 1'b1, 1'b0, 2'b00, 12'd4095, 1,   12'd0,    3'(IDLE),  1'b0, 1'b0, "mid_reset"});  // 978

    foreach (tbl[i]) begin
      reset = tbl[i].rst_n; run = tbl[i].run; stop_req = tbl[i].stop;
      OC = tbl[i].oc; target_duty = tbl[i].tgt;
      step(tbl[i].cycles);
      chk_all(tbl[i].name, tbl[i].e_duty, tbl[i].e_state, tbl[i].e_fault, tbl[i].e_active);
    end

    // Fault then cooldown: auto-retry returns to IDLE after 8 clean ticks only when enabled
    reset = 1'b1; run = 1'b1; stop_req = 1'b0; OC = 2'b00; target_duty = 12'd200;
    step(1);  chk_all("r_start", 12'd0, 3'(RAMP), 1'b0, 1'b0);
    step(11); chk_all("r_up3",   12'd192, 3'(RAMP), 1'b0, 1'b1);
    step(4);  chk_all("r_sat",   12'd200, 3'(HOLD), 1'b0, 1'b1);
    OC = 2'b10;
    step(15); chk_all("r_oc3",   12'd200, 3'(HOLD), 1'b0, 1'b1);
    step(1);  chk_all("r_trip",  12'd0, 3'(FAULT), 1'b1, 1'b0);
    OC = 2'b00;
    step(31); chk_all("r_cool7", 12'd0, 3'(FAULT), 1'b1, 1'b0);
    step(1);  chk_all("r_cool8", 12'd0, RETRY ? 3'(IDLE) : 3'(FAULT), !RETRY, 1'b0);
    step(1);  chk_all("r_rerun", 12'd0, RETRY ? 3'(RAMP) : 3'(FAULT), !RETRY, 1'b0);
    step(3);  chk_all("r_reup",  RETRY ? 12'd64 : 12'd0, RETRY ? 3'(RAMP) : 3'(FAULT), !RETRY, RETRY);
    run = 1'b0;
    step(1);
    chk("r_off.state", 16'(state), RETRY ? 16'(BRAKE) : 16'(IDLE));
    chk("r_off.fault", 16'(fault), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
